cs_result_fifo: RTL
===================

Name: cs_result_fifo

Overview:
- Downstream stage of the CS sliding-window computational block. Consumes its 10-bit result Y and suppresses results taken while the 9-sample window is still partly reset zeros.
- Buffers each valid result in a small show-ahead FIFO with a valid/ready read handshake toward the consumer (output formatter or test harness).
- Shares clk and reset with the CS block.

Parameters:
- Y_W, 10, result width (matches CS Y)
- WIN, 9, window length in samples; results before the window is full are discarded
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; shared with the CS block
- in_en  input  1  high on every edge at which the CS block shifts in a new X
- y_in  input  Y_W  CS result Y (combinational in CS, reflects the current window)
- rd_ready  input  1  consumer accepts dout this cycle
- clr_ovf  input  1  synchronous clear of overflow
- dout  output  Y_W  FIFO head; 0 when dout_valid=0
- dout_valid  output  1  FIFO not empty
- win_full  output  1  window holds WIN real samples
- count  output  clog2(DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky; a result was dropped because the FIFO was full

Behaviour:
- Reset (async, active-high): win_cnt=0, pend=0, FIFO pointers and count=0, overflow=0. All outputs read 0 while reset is held.
- Warm-up counter win_cnt (width clog2(WIN+1)):
  - +1 on each edge with in_en=1; saturates at WIN.
  - win_full = (win_cnt==WIN).
- pend register: pend <= in_en every edge. It marks that y_in now reflects a freshly shifted window.
- Push condition: push = pend && win_full, evaluated at the edge. y_in is written at wr_ptr.
  - First push occurs at the edge after the WIN-th in_en edge.
  - Latency: 1 cycle from the window-completing shift to the result being captured; dout_valid rises after that edge.
  - The last result of a stream is pushed even if in_en drops.
- Pop: pop = dout_valid && rd_ready. rd_ptr advances at the edge.
- Show-ahead read: dout = mem[rd_ptr] combinationally when count>0, otherwise 0.
- Full with push and no pop: result dropped, pointers and count unchanged, overflow <= 1.
- Full with push and pop together: both happen, count stays DEPTH, no overflow.
- Empty with push and pop together: pop is ignored (dout_valid=0), push proceeds, count becomes 1.
- Pointers wrap modulo DEPTH. count is tracked explicitly and ranges 0..DEPTH.
- overflow: sticky. Cleared by reset, or by clr_ovf at the edge. If clr_ovf and a new overflow coincide, overflow ends at 1 (set wins).
- Reset mid-operation: everything clears immediately. The CS window also clears, so warm-up restarts and no result is pushed until WIN further in_en edges have occurred.
- Arithmetic: y_in is stored unmodified. No width change, no saturation.

Decomposition:
- Shared package cs_pkg: constants CS_X_W=8, CS_Y_W=10, CS_WIN=9. Y_W and WIN default from these.
- One sub-module: cs_sync_fifo. It holds storage, pointers, count, full/empty and overflow, and is parameterised by width and depth.
- Warm-up counter and pend logic stay in the top module (about 40 lines). The FIFO is about 120 lines.

Test Plan:
- Constant X=16, in_en=1 every cycle, rd_ready=1 -> no dout_valid for the first 9 edges. dout_valid rises after edge 10 with dout=36, i.e. (144+144)>>3. dout then stays 36 with continuous valid; count never exceeds 1.
- rd_ready=0 with a steady stream after warm-up -> count goes 1,2,3,4. The 5th push sets overflow=1 and count stays 4. dout shows the first captured value throughout. clr_ovf pulse -> overflow=0.
- FIFO full, rd_ready=1 while pushes continue -> count holds at 4, overflow stays 0. Outputs appear in push order with none lost.
- in_en pulsed every other cycle after warm-up -> exactly one push per in_en pulse, each one cycle after the pulse. No pushes occur on idle cycles.
- Reset asserted after 5 in_en edges, released, stream resumed -> win_full=0 and no push for 9 further in_en edges. The first push comes at the 10th edge after release.
- Empty FIFO with rd_ready=1 held -> dout=0 and dout_valid=0, count stays 0. No pointer movement (check via the later push order).

Source files
------------

// File: rtl/cs_pkg.sv
// Shared constants for the CS sliding-window block and its downstream stages.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cs_pkg;

  localparam int CS_X_W = 8;   // input sample width
  localparam int CS_Y_W = 10;  // result width
  localparam int CS_WIN = 9;   // window length in samples

  // Counter width needed to hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cs_result_fifo_if.sv
// Show-ahead read handshake between the result FIFO and its consumer.
// Latency: n/a (wiring only).
// Backpressure: consumer holds rd_ready low to stall; dout stays stable meanwhile.
interface cs_result_if #(
  parameter int W = 10
);
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         rd_ready;

  modport master (
    output dout,
    output dout_valid,
    input  rd_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output rd_ready
  );
endinterface

// File: rtl/cs_sync_fifo.sv
// Generic show-ahead synchronous FIFO with explicit occupancy and sticky overflow.
// Latency: a push is visible at dout the cycle after its edge when the FIFO was empty.
// Backpressure: none upstream; a push into a full FIFO without a pop is dropped and flagged.
module cs_sync_fifo #(
  parameter  int W     = 10,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          clr_ovf,
  output logic [W-1:0]  dout,
  output logic          dout_valid,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;
  logic          ovf_set;

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign dout_valid = !empty;
  assign dout       = empty ? '0 : mem[rd_ptr];

  // Qualify requests: a pop on empty is ignored; a push on full only succeeds
  // if a pop frees the head slot at the same edge, otherwise it is dropped.
  always_comb begin
    do_pop  = 1'b0;
    do_push = 1'b0;
    ovf_set = 1'b0;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    ovf_set = push && full && !do_pop;
  end

  // Storage write; contents need no reset because dout is gated by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a new drop takes priority over a clear at the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/cs_result_fifo.sv
// Captures CS window results once the window is full and queues them for a consumer.
// Latency: result captured 1 edge after the shift that produced it; dout_valid follows that edge.
// Backpressure: rd_ready stalls the reader; results arriving at a full FIFO are dropped (overflow).
module cs_result_fifo
  import cs_pkg::*;
#(
  parameter  int Y_W   = CS_Y_W,
  parameter  int WIN   = CS_WIN,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int WCW   = cnt_w(WIN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_en,
  input  logic [Y_W-1:0]  y_in,
  input  logic            clr_ovf,
  cs_result_if.master     rd,
  output logic            win_full,
  output logic [CW-1:0]   count,
  output logic            overflow
);

  localparam logic [WCW-1:0] WIN_CNT = WCW'(WIN);

  logic [WCW-1:0] win_cnt;
  logic           pend;
  logic           push;
  logic           pop;

  assign win_full = (win_cnt == WIN_CNT);
  // pend says y_in now reflects a freshly shifted window; only push once the
  // window holds real samples rather than reset zeros.
  assign push     = pend && win_full;
  assign pop      = rd.dout_valid && rd.rd_ready;

  // Warm-up counter saturating at WIN, plus one-cycle marker of a new shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt <= '0;
      pend    <= 1'b0;
    end else begin
      if (in_en && !win_full) begin
        win_cnt <= win_cnt + 1'b1;
      end
      pend <= in_en;
    end
  end

  cs_sync_fifo #(
    .W     (Y_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .din        (y_in),
    .pop        (pop),
    .clr_ovf    (clr_ovf),
    .dout       (rd.dout),
    .dout_valid (rd.dout_valid),
    .count      (count),
    .overflow   (overflow)
  );

endmodule
